// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit registered ALU with ARM-style NZCV flags
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlag
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_BIC = 3'b101,
    OP_MUL = 3'b110,
    OP_MOV = 3'b111
  } alu_op_e;

  alu_op_e     op;
  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic [31:0] prod;
  logic [31:0] res_d;
  logic        carry_d;
  logic        ovf_d;
  logic [3:0]  flag_d;

  assign op = alu_op_e'(ALUControl);

  // SUB shares the adder: a + ~b + 1, so carry-out means "no borrow".
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
  assign prod   = a * b;

  always_comb begin
    res_d   = 32'd0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        res_d   = sum[31:0];
        carry_d = sum[32];
        ovf_d   = (a[31] == b_eff[31]) && (sum[31] != a[31]);
      end
      OP_AND: res_d = a & b;
      OP_ORR: res_d = a | b;
      OP_EOR: res_d = a ^ b;
      OP_BIC: res_d = a & ~b;
      OP_MUL: res_d = prod;
      OP_MOV: res_d = b;
      default: res_d = 32'd0;
    endcase
  end

  assign flag_d = {res_d[31], (res_d == 32'd0), carry_d, ovf_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      Result  <= 32'd0;
      ALUFlag <= 4'b0000;
    end else begin
      Result  <= res_d;
      ALUFlag <= flag_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ALUControl;
  logic [31:0] Result;
  logic [3:0]  ALUFlag;

  int checks;
  int errors;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_core dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .Result     (Result),
    .ALUFlag    (ALUFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {N,Z,C,V, result} from wide integer arithmetic.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned wide;
    longint sx;
    longint sy;
    longint s;
    logic [31:0] r;
    logic c;
    logic v;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0;
    v = 1'b0;
    r = 32'd0;
    case (op)
      3'd0: begin
        wide = ux + uy;
        r = wide[31:0];
        c = (wide > 64'h0000_0000_FFFF_FFFF);
        s = sx + sy;
        v = (s > SMAX) || (s < SMIN);
      end
      3'd1: begin
        wide = ux - uy;
        r = wide[31:0];
        c = (ux >= uy);
        s = sx - sy;
        v = (s > SMAX) || (s < SMIN);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x & ~y;
      3'd6: begin
        wide = ux * uy;
        r = wide[31:0];
      end
      default: r = y;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_r, input logic [3:0] exp_f);
    checks++;
    assert ({ALUFlag, Result} === {exp_f, exp_r})
    else begin
      errors++;
      $error("FAIL %s: got Result=%h ALUFlag=%b, expected Result=%h ALUFlag=%b",
             tag, Result, ALUFlag, exp_r, exp_f);
    end
  endtask

  // Apply one operation away from the edge, then sample #1 after the edge.
  task automatic step(input logic r, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    rst = r;
    ALUControl = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_r, input logic [3:0] exp_f);
    step(1'b0, op, x, y);
    check(tag, exp_r, exp_f);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [35:0] exp;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    ALUControl = 3'd0;

    // Reset held for two cycles with non-zero inputs
    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1);
    check("reset_cycle1", 32'h0, 4'b0000);
    step(1'b1, 3'd6, 32'hDEAD_BEEF, 32'h1234);
    check("reset_cycle2", 32'h0, 4'b0000);

    // Core ops
    op_check("add_3_5",  3'd0, 32'd3, 32'd5, 32'd8,  4'b0000);
    op_check("sub_5_5",  3'd1, 32'd5, 32'd5, 32'd0,  4'b0110);
    op_check("and_8_1",  3'd2, 32'd8, 32'd1, 32'd0,  4'b0100);
    op_check("orr_5_7",  3'd3, 32'd5, 32'd7, 32'd7,  4'b0000);
    op_check("mul_9_6",  3'd6, 32'd9, 32'd6, 32'd54, 4'b0000);

    // Arithmetic corners
    op_check("add_ovf",     3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    op_check("add_wrap",    3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b0110);
    op_check("sub_borrow",  3'd1, 32'd3,         32'd5, 32'hFFFF_FFFE, 4'b1000);
    op_check("sub_ovf",     3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011);

    // Remaining ops
    op_check("eor", 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
    op_check("bic", 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 4'b0000);
    op_check("mov", 3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFF00_FF00, 4'b1000);
    op_check("mul_hi_lost", 3'd6, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0100);

    // Back-to-back burst with reset in the middle
    for (int i = 0; i < 8; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      rop = 3'(i);
      if (i == 4) begin
        step(1'b1, rop, ra, rb);
        check("burst_reset", 32'h0, 4'b0000);
      end else begin
        step(1'b0, rop, ra, rb);
        exp = model(rop, ra, rb);
        check($sformatf("burst_op%0d", i), exp[31:0], exp[35:32]);
      end
    end

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      rop = 3'($urandom_range(0, 7));
      step(1'b0, rop, ra, rb);
      exp = model(rop, ra, rb);
      check($sformatf("rand%0d_op%0d", i, rop), exp[31:0], exp[35:32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
